// File: rtl/shift_reg_ctrl.sv
// shift_reg_ctrl: sequencer for a serial-in/parallel-out shift register.
// Accepts a word, serializes it into the register over WIDTH shift cycles,
// captures the parallel output and reports it with a mismatch flag.
module shift_reg_ctrl #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             sr_s_in,
  output logic             sr_shift_en,
  input  logic [WIDTH-1:0] sr_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SHIFT   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Mirror image of a word: bit i moves to bit WIDTH-1-i.
  function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = w[WIDTH-1-i];
    end
    return r;
  endfunction

  // Word the register should hold after WIDTH shifts of this input.
  function automatic logic [WIDTH-1:0] expected_word(input logic [WIDTH-1:0] d);
    if (MSB_FIRST) begin
      return d;
    end else begin
      return bit_reverse(d);
    end
  endfunction

  // Advance the hold register toward the serialized end, zero-filling.
  function automatic logic [WIDTH-1:0] shift_hold(input logic [WIDTH-1:0] h);
    if (MSB_FIRST) begin
      return {h[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, h[WIDTH-1:1]};
    end
  endfunction

  logic [1:0]       state_r;
  logic [1:0]       state_s;
  logic [WIDTH-1:0] hold_r;
  logic [WIDTH-1:0] exp_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] out_data_r;
  logic             err_r;
  logic             serial_bit_s;

  // Next-state decode; handshakes only move the FSM out of IDLE and DONE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == CNT_LAST) begin
          state_s = CAPTURE;
        end else begin
          state_s = SHIFT;
        end
      end
      CAPTURE: state_s = DONE;
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, datapath and result registers; reset aborts any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      hold_r     <= {WIDTH{1'b0}};
      exp_r      <= {WIDTH{1'b0}};
      cnt_r      <= {CW{1'b0}};
      out_data_r <= {WIDTH{1'b0}};
      err_r      <= 1'b0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            hold_r <= in_data;
            exp_r  <= expected_word(in_data);
            cnt_r  <= {CW{1'b0}};
          end else begin
            hold_r <= hold_r;
          end
        end
        SHIFT: begin
          hold_r <= shift_hold(hold_r);
          cnt_r  <= cnt_r + CNT_ONE;
        end
        CAPTURE: begin
          out_data_r <= sr_q;
          err_r      <= (sr_q != exp_r);
        end
        DONE: begin
          out_data_r <= out_data_r;
        end
        default: begin
          hold_r <= hold_r;
        end
      endcase
    end
  end

  // Bit presented to the register: the end of hold that leaves first.
  always_comb begin
    if (MSB_FIRST) begin
      serial_bit_s = hold_r[WIDTH-1];
    end else begin
      serial_bit_s = hold_r[0];
    end
  end

  assign in_ready    = (state_r == IDLE);
  assign busy        = (state_r != IDLE);
  assign out_valid   = (state_r == DONE);
  assign sr_shift_en = (state_r == SHIFT);
  assign sr_s_in     = sr_shift_en & serial_bit_s;
  assign out_data    = out_data_r;
  assign err         = err_r;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Directed bench for shift_reg_ctrl: an MSB-first instance (with an optional
// stuck-at fault in its shift register) and an LSB-first instance.
module tb_shift_reg_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: MSB first
  logic       a_in_valid = 1'b0, a_in_ready, a_s_in, a_shift_en;
  logic [3:0] a_in_data = 4'h0, a_q, a_sr_q, a_out_data;
  logic       a_out_valid, a_out_ready = 1'b0, a_err, a_busy;
  logic       fault = 1'b0;

  // Instance B: LSB first
  logic       b_in_valid = 1'b0, b_in_ready, b_s_in, b_shift_en;
  logic [3:0] b_in_data = 4'h0, b_q, b_out_data;
  logic       b_out_valid, b_out_ready = 1'b0, b_err, b_busy;

  int checks = 0;
  int errors = 0;

  shift_reg_ctrl #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .sr_s_in(a_s_in), .sr_shift_en(a_shift_en),
    .sr_q(a_sr_q), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .err(a_err), .busy(a_busy));

  shift_reg_ctrl #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .sr_s_in(b_s_in), .sr_shift_en(b_shift_en),
    .sr_q(b_q), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .err(b_err), .busy(b_busy));

  // SIPO shift register models sharing clk/rst with the controllers
  always @(posedge clk) begin
    if (rst) a_q <= 4'h0;
    else if (a_shift_en) a_q <= {a_q[2:0], a_s_in};
  end
  always @(posedge clk) begin
    if (rst) b_q <= 4'h0;
    else if (b_shift_en) b_q <= {b_q[2:0], b_s_in};
  end
  assign a_sr_q = fault ? (a_q & 4'hE) : a_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Send a word to instance A, wait (bounded) for its result and retire it.
  task automatic run_a(input logic [3:0] d, input logic [3:0] exp_d, input logic exp_e,
                       input string tag);
    int n;
    a_in_data = d;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    n = 0;
    while (!a_out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(a_out_valid), 32'd1);
    chk({tag, "_data"}, 32'(a_out_data), 32'(exp_d));
    chk({tag, "_err"}, 32'(a_err), 32'(exp_e));
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] seq;
    logic [3:0] res1;
    logic       res1_err;
    logic       got1;
    int         acc2;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_s_in", 32'(a_s_in), 32'd0);
    chk("rst_shift_en", 32'(a_shift_en), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_out_data", 32'(a_out_data), 32'd0);

    // Basic MSB-first: 4'b1100 -> 1,1,0,0
    seq = 4'b0011;  // expected s_in per shift cycle, index 0 first
    a_in_data = 4'hC;
    a_in_valid = 1'b1;
    tick();  // E0
    a_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("msb_shift_en_%0d", i), 32'(a_shift_en), 32'd1);
      chk($sformatf("msb_s_in_%0d", i), 32'(a_s_in), 32'(seq[i]));
      tick();  // E1..E4
    end
    chk("msb_cap_shift_en", 32'(a_shift_en), 32'd0);
    chk("msb_cap_s_in", 32'(a_s_in), 32'd0);
    chk("msb_cap_out_valid", 32'(a_out_valid), 32'd0);
    tick();  // E5
    chk("msb_out_valid", 32'(a_out_valid), 32'd1);
    chk("msb_out_data", 32'(a_out_data), 32'hC);
    chk("msb_err", 32'(a_err), 32'd0);

    // Backpressure: 3 cycles with out_ready low
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_out_valid", 32'(a_out_valid), 32'd1);
      chk("bp_out_data", 32'(a_out_data), 32'hC);
      chk("bp_err", 32'(a_err), 32'd0);
      chk("bp_in_ready", 32'(a_in_ready), 32'd0);
      chk("bp_busy", 32'(a_busy), 32'd1);
    end
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    chk("bp_rel_in_ready", 32'(a_in_ready), 32'd1);
    chk("bp_rel_out_valid", 32'(a_out_valid), 32'd0);
    chk("bp_rel_busy", 32'(a_busy), 32'd0);

    // LSB-first: 4'b1100 -> 0,0,1,1, result 4'b0011
    seq = 4'b1100;
    b_in_data = 4'hC;
    b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("lsb_shift_en_%0d", i), 32'(b_shift_en), 32'd1);
      chk($sformatf("lsb_s_in_%0d", i), 32'(b_s_in), 32'(seq[i]));
      tick();
    end
    tick();
    chk("lsb_out_valid", 32'(b_out_valid), 32'd1);
    chk("lsb_out_data", 32'(b_out_data), 32'h3);
    chk("lsb_err", 32'(b_err), 32'd0);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    chk("lsb_in_ready", 32'(b_in_ready), 32'd1);

    // Reset mid-shift after 2 shift edges of 4'hA
    a_in_data = 4'hA;
    a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("mid_rst_shift_en", 32'(a_shift_en), 32'd0);
    chk("mid_rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("mid_rst_busy", 32'(a_busy), 32'd0);
    run_a(4'h5, 4'h5, 1'b0, "after_rst");

    // Fault detection: q[0] stuck at 0
    fault = 1'b1;
    run_a(4'hF, 4'hE, 1'b1, "fault");
    fault = 1'b0;

    // Back-to-back with in_valid held high
    a_out_ready = 1'b1;
    a_in_data = 4'h3;
    a_in_valid = 1'b1;
    tick();  // first acceptance at E0
    a_in_data = 4'h9;
    acc2 = -1;
    got1 = 1'b0;
    res1 = 4'h0;
    res1_err = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();  // now after edge E_k
      if (a_out_valid && !got1) begin
        got1 = 1'b1;
        res1 = a_out_data;
        res1_err = a_err;
      end
      if (a_in_ready) begin
        acc2 = k + 1;
        break;
      end
    end
    chk("b2b_spacing", 32'(acc2), 32'd7);
    chk("b2b_res1_seen", 32'(got1), 32'd1);
    chk("b2b_res1_data", 32'(res1), 32'h3);
    chk("b2b_res1_err", 32'(res1_err), 32'd0);
    tick();  // second acceptance
    a_in_valid = 1'b0;
    chk("b2b_accepted", 32'(a_busy), 32'd1);
    for (int k = 0; k < 20; k++) begin
      if (a_out_valid) break;
      tick();
    end
    chk("b2b_res2_valid", 32'(a_out_valid), 32'd1);
    chk("b2b_res2_data", 32'(a_out_data), 32'h9);
    chk("b2b_res2_err", 32'(a_err), 32'd0);
    tick();
    a_out_ready = 1'b0;
    chk("b2b_idle", 32'(a_in_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_reg_ctrl.md
Name: shift_reg_ctrl

Overview:
- Sequencer for a serial-in/parallel-out shift register. It accepts a parallel word over a valid/ready handshake and drives the register's serial input and shift enable for exactly WIDTH cycles.
- It then captures the register's parallel output and presents the result with a pass/fail flag over a second valid/ready handshake.
- It sits between a word producer and the SIPO shift register, which shares the same clk and rst.

Parameters:
- WIDTH, 4, data width of the word and of the controlled shift register; legal range WIDTH >= 2.
- MSB_FIRST, 1, 1 = serialize from in_data[WIDTH-1] down; 0 = serialize from in_data[0] up.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  controller can accept a word (high only in IDLE).
- in_data  input  WIDTH  word to serialize.
- sr_s_in  output  1  serial bit to shift register s_in.
- sr_shift_en  output  1  shift enable to shift register.
- sr_q  input  WIDTH  shift register parallel output q_out.
- out_valid  output  1  captured result available.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  captured sr_q.
- err  output  1  out_data differs from expected word; valid only with out_valid.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Downstream shift register contract: when sr_shift_en = 1, q <= {q[WIDTH-2:0], s_in} on the edge.
- Expected word:
  - MSB_FIRST = 1: in_data.
  - MSB_FIRST = 0: bit-reversed in_data.
- States: IDLE, SHIFT, CAPTURE, DONE. Internal registers: hold[WIDTH], exp[WIDTH], cnt of width $clog2(WIDTH+1).
- Reset (rst high at an edge): state = IDLE, cnt = 0, hold = 0, exp = 0, out_data = 0. Outputs after reset: in_ready = 1, out_valid = 0, err = 0, sr_s_in = 0, sr_shift_en = 0, busy = 0.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid & in_ready: hold <= in_data, exp <= expected word, cnt <= 0, state <= SHIFT.
- SHIFT:
  - sr_shift_en = 1.
  - sr_s_in = hold[WIDTH-1] if MSB_FIRST, else hold[0]. This output is combinational from hold.
  - Each edge: hold shifts toward the serialized end, zero-filled; cnt <= cnt + 1.
  - When cnt == WIDTH-1 at an edge: state <= CAPTURE. Exactly WIDTH shift edges occur.
- CAPTURE:
  - sr_shift_en = 0, sr_s_in = 0.
  - Next edge: out_data <= sr_q, err <= (sr_q != exp), state <= DONE.
- DONE:
  - out_valid = 1; out_data and err are held stable.
  - On an edge with out_ready = 1: state <= IDLE. out_valid drops the following cycle.
  - out_ready low holds DONE indefinitely.
- Latency: handshake at edge E0, shift edges E1..EW, capture at E(W+1), out_valid high from E(W+1). Minimum word-to-word spacing is WIDTH+3 cycles.
- Registered outputs: in_ready, busy, out_valid, sr_shift_en are decoded from the registered state only; there is no combinational path from in_valid or out_ready.
- in_valid outside IDLE is ignored; the word must be held by the producer until accepted.
- in_data changes after acceptance have no effect.
- Reset mid-operation (any state) returns to IDLE on that edge. No partial result is emitted, and out_valid never asserts for the aborted word.
- rst has priority over every handshake occurring on the same edge.
- sr_q is sampled only in CAPTURE; its value at other times is don't-care.

Test Plan:
- Basic MSB-first: WIDTH=4, MSB_FIRST=1, real 4-bit shift register, in_data=4'b1100 -> sr_s_in over the 4 shift cycles = 1,1,0,0; sr_shift_en high exactly 4 cycles; out_valid at E5 with out_data=4'hC, err=0.
- LSB-first: MSB_FIRST=0, in_data=4'b1100 -> sr_s_in = 0,0,1,1; out_data=4'b0011, err=0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_valid, out_data and err stable; in_ready=0, busy=1; release -> IDLE one cycle later with in_ready=1.
- Reset mid-shift: assert rst for 1 cycle after 2 shift edges of 4'hA -> next cycle in_ready=1, sr_shift_en=0, out_valid=0; a new word 4'h5 then completes with out_data=4'h5, err=0.
- Fault detection: shift register model with q[0] stuck at 0, in_data=4'hF -> out_data=4'hE, err=1.
- Back-to-back: in_valid held high with 4'h3 then 4'h9 and out_ready=1 -> second acceptance exactly WIDTH+3 = 7 cycles after the first; results 4'h3 then 4'h9, both err=0.
